// File: rtl/register_file_mp.sv
// register_file_mp: multi-port register file with two write ports, optional write-to-read
// bypass and a per-register busy scoreboard used by decode to stall on RAW hazards.
module register_file_mp #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NR_READ    = 2,
  parameter int BYPASS     = 1
)(
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NR_READ*ADDR_WIDTH-1:0]  rs,
  output logic [NR_READ*DATA_WIDTH-1:0]  rdata,
  output logic [NR_READ-1:0]             rbusy,
  input  logic                           wen0,
  input  logic [ADDR_WIDTH-1:0]          waddr0,
  input  logic [DATA_WIDTH-1:0]          wdata0,
  input  logic                           wen1,
  input  logic [ADDR_WIDTH-1:0]          waddr1,
  input  logic [DATA_WIDTH-1:0]          wdata1,
  input  logic                           iss_valid,
  input  logic [ADDR_WIDTH-1:0]          iss_rd,
  output logic [ADDR_WIDTH:0]            busy_cnt
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy, busy_next;
  logic [ADDR_WIDTH:0]   cnt_next;
  // issue is applied after writeback clear so a new producer wins; x0 is never busy
  always_comb begin
    busy_next = busy;
    if (wen0) busy_next[waddr0] = 1'b0;
    if (iss_valid) busy_next[iss_rd] = 1'b1;
    busy_next[0] = 1'b0;
    cnt_next = '0;
    for (int i = 0; i < DEPTH; i++) cnt_next = cnt_next + {{ADDR_WIDTH{1'b0}}, busy_next[i]};
  end
  // port 1 write follows port 0 so it wins on an address collision
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
      for (int k = 0; k < DEPTH; k++) regs[k] <= '0;
    end else begin
      busy     <= busy_next;
      busy_cnt <= cnt_next;
      if (wen0 && waddr0 != '0) regs[waddr0] <= wdata0;
      if (wen1 && waddr1 != '0) regs[waddr1] <= wdata1;
    end
  for (genvar g = 0; g < NR_READ; g++) begin : g_rd
    logic [ADDR_WIDTH-1:0] a;
    assign a = rs[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign rdata[g*DATA_WIDTH +: DATA_WIDTH] =
      (a == '0)                                ? '0     :
      (BYPASS != 0 && wen1 && waddr1 == a)     ? wdata1 :
      (BYPASS != 0 && wen0 && waddr0 == a)     ? wdata0 : regs[a];
    assign rbusy[g] = busy[a];
  end
endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: directed table, corner sequences and randomized run against an array model.
module tb_register_file_mp;
  logic         clk = 1'b0;
  logic         rst;
  logic [19:0]  rs;
  logic [127:0] rdata;
  logic [3:0]   rbusy;
  logic         wen0, wen1, iss_valid;
  logic [4:0]   waddr0, waddr1, iss_rd;
  logic [31:0]  wdata0, wdata1;
  logic [5:0]   busy_cnt;
  logic [31:0]  rdata_nb;
  logic         rbusy_nb;
  logic [5:0]   cnt_nb;
  int n_cmp = 0, n_err = 0;
  logic [31:0] mem [32];
  bit          bsy [32];

  always #5 clk = ~clk;

  register_file_mp #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NR_READ(4), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .rs(rs), .rdata(rdata), .rbusy(rbusy),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .busy_cnt(busy_cnt));

  register_file_mp #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NR_READ(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rs(rs[4:0]), .rdata(rdata_nb), .rbusy(rbusy_nb),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .busy_cnt(cnt_nb));

  typedef struct {
    logic w0; logic [4:0] a0; logic [31:0] d0;
    logic w1; logic [4:0] a1; logic [31:0] d1;
    logic iv; logic [4:0] ir; logic [4:0] ra;
    logic [31:0] e_rd; logic [31:0] e_nb; logic e_busy; logic [5:0] e_cnt;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] port(input int i);
    return rdata[i*32 +: 32];
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 0) return 32'h0;
    if (byp && wen1 && waddr1 == a) return wdata1;
    if (byp && wen0 && waddr0 == a) return wdata0;
    return mem[a];
  endfunction

  function automatic logic [5:0] exp_cnt();
    int c = 0;
    for (int r = 0; r < 32; r++) c += int'(bsy[r]);
    return 6'(c);
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin mem[r] = 0; bsy[r] = 0; end
  endtask

  task automatic idle();
    wen0 = 0; wen1 = 0; iss_valid = 0;
  endtask

  // advance one edge, mirror the architectural effect of the inputs held at that edge
  task automatic tick();
    @(posedge clk);
    if (rst) model_clear();
    else begin
      if (wen0 && waddr0 != 0) mem[waddr0] = wdata0;
      if (wen1 && waddr1 != 0) mem[waddr1] = wdata1;
      if (wen0) bsy[waddr0] = 0;
      if (iss_valid && iss_rd != 0) bsy[iss_rd] = 1;
    end
    #1;
  endtask

  initial begin
    rst = 1; rs = '0; idle();
    waddr0 = 0; waddr1 = 0; iss_rd = 0; wdata0 = 0; wdata1 = 0;
    model_clear();
    #12;
    chk("reset_cnt", 32'(busy_cnt), 0);
    chk("reset_rd", port(0), 0);
    rst = 0;
    @(posedge clk); #1;
    // reset: build state in x5 then assert rst between edges
    iss_valid = 1; iss_rd = 5; tick(); idle();
    wen1 = 1; waddr1 = 5; wdata1 = 32'hDEADBEEF; tick(); idle();
    rs[4:0] = 5; #1;
    chk("pre_reset_rd", port(0), 32'hDEADBEEF);
    chk("pre_reset_cnt", 32'(busy_cnt), 1);
    #2 rst = 1; #1;
    model_clear();
    chk("async_reset_rd", port(0), 0);
    chk("async_reset_cnt", 32'(busy_cnt), 0);
    chk("async_reset_rbusy", 32'(rbusy[0]), 0);
    wen0 = 1; waddr0 = 5; wdata0 = 32'h99; iss_valid = 1; iss_rd = 5;
    tick(); idle(); rst = 0; #1;
    chk("reset_discard_rd", port(0), 0);
    chk("reset_discard_cnt", 32'(busy_cnt), 0);
    // directed table: same-cycle reads, then rbusy/busy_cnt after the edge
    tbl[0]  = '{1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 32'h0,  1'b1, 5'd0, 5'd0, 32'h0,  32'h0,  1'b0, 6'd0};
    tbl[1]  = '{1'b1, 5'd3, 32'h11,       1'b1, 5'd3, 32'h22, 1'b0, 5'd0, 5'd3, 32'h22, 32'h0,  1'b0, 6'd0};
    tbl[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd3, 32'h22, 32'h22, 1'b0, 6'd0};
    tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd7, 5'd7, 32'h0,  32'h0,  1'b1, 6'd1};
    tbl[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd7, 32'h0,  32'h0,  1'b1, 6'd1};
    tbl[5]  = '{1'b1, 5'd7, 32'hAB,       1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd7, 32'hAB, 32'h0,  1'b0, 6'd0};
    tbl[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd9, 5'd9, 32'h0,  32'h0,  1'b1, 6'd1};
    tbl[7]  = '{1'b1, 5'd9, 32'h55,       1'b0, 5'd0, 32'h0,  1'b1, 5'd9, 5'd9, 32'h55, 32'h0,  1'b1, 6'd1};
    tbl[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd9, 32'h55, 32'h55, 1'b1, 6'd1};
    tbl[9]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h66, 1'b0, 5'd0, 5'd9, 32'h66, 32'h55, 1'b1, 6'd1};
    tbl[10] = '{1'b1, 5'd9, 32'h77,       1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd9, 32'h77, 32'h66, 1'b0, 6'd0};
    for (int v = 0; v < 11; v++) begin
      wen0 = tbl[v].w0; waddr0 = tbl[v].a0; wdata0 = tbl[v].d0;
      wen1 = tbl[v].w1; waddr1 = tbl[v].a1; wdata1 = tbl[v].d1;
      iss_valid = tbl[v].iv; iss_rd = tbl[v].ir; rs[4:0] = tbl[v].ra;
      #1;
      chk($sformatf("tbl%0d_rd", v), port(0), tbl[v].e_rd);
      chk($sformatf("tbl%0d_rd_nobyp", v), rdata_nb, tbl[v].e_nb);
      tick(); idle();
      chk($sformatf("tbl%0d_rbusy", v), 32'(rbusy[0]), 32'(tbl[v].e_busy));
      chk($sformatf("tbl%0d_cnt", v), 32'(busy_cnt), 32'(tbl[v].e_cnt));
    end
    // full scoreboard, then drain with index data and read on four ports
    for (int r = 1; r < 32; r++) begin iss_valid = 1; iss_rd = 5'(r); tick(); end
    idle();
    chk("full_cnt", 32'(busy_cnt), 31);
    for (int r = 1; r < 32; r++) begin wen0 = 1; waddr0 = 5'(r); wdata0 = r; tick(); end
    idle();
    rs = {5'd31, 5'd20, 5'd10, 5'd1}; #1;
    chk("drain_p0", port(0), 1);
    chk("drain_p1", port(1), 10);
    chk("drain_p2", port(2), 20);
    chk("drain_p3", port(3), 31);
    chk("drain_cnt", 32'(busy_cnt), 0);
    // randomized traffic on a narrow address window to force collisions
    for (int c = 0; c < 400; c++) begin
      wen0 = 1'($urandom_range(0, 1)); waddr0 = 5'($urandom_range(0, 7)); wdata0 = $urandom;
      wen1 = ($urandom_range(0, 4) == 0); waddr1 = 5'($urandom_range(0, 7)); wdata1 = $urandom;
      iss_valid = 1'($urandom_range(0, 1)); iss_rd = 5'($urandom_range(0, 7));
      for (int p = 0; p < 4; p++) rs[p*5 +: 5] = 5'($urandom_range(0, 7));
      #1;
      for (int p = 0; p < 4; p++) begin
        chk($sformatf("rnd%0d_rd%0d", c, p), port(p), exp_rd(rs[p*5 +: 5], 1'b1));
        chk($sformatf("rnd%0d_rbusy%0d", c, p), 32'(rbusy[p]), 32'(bsy[rs[p*5 +: 5]]));
      end
      chk($sformatf("rnd%0d_rd_nobyp", c), rdata_nb, exp_rd(rs[4:0], 1'b0));
      chk($sformatf("rnd%0d_cnt", c), 32'(busy_cnt), 32'(exp_cnt()));
      tick();
    end
    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
